dm_scan_checker: RTL and testbench
==================================

// Module: dm_scan_checker
// PURPOSE
//   Read-side companion to the CPU's data-memory writes. After a program has stored
//   an array (e.g. bubble-sort output), this block walks N consecutive words from a
//   base byte address and streams each word out over a valid/ready port. It checks
//   that the words are strictly ascending as signed values and reports pass/fail
//   plus the first offending index. It sits beside b2v_DM on a secondary read port
//   while the CPU is halted or held in reset.
// PARAMETERS
//   DATA_W  32  memory word width
//   ADDR_W  32  byte-address width
//   CNT_W   16  width of num_words, the word index and fail_idx
// PORTS
//   clk          in   1       rising-edge clock
//   rst          in   1       synchronous, active-high reset
//   start        in   1       one-cycle request to begin a scan; sampled only in IDLE
//   base_addr    in   ADDR_W  byte address of word 0; must be word-aligned
//   num_words    in   CNT_W   number of words N to scan
//   mem_addr     out  ADDR_W  byte read address to data memory
//   mem_rd       out  1       read strobe; memory returns mem_rdata the next cycle
//   mem_rdata    in   DATA_W  read data, valid one cycle after mem_rd
//   out_data     out  DATA_W  streamed word
//   out_valid    out  1       out_data valid
//   out_ready    in   1       consumer accepts the word when out_valid && out_ready
//   busy         out  1       high from the cycle after an accepted start until DONE
//   done         out  1       one-cycle pulse at the end of a scan
//   sorted       out  1       1 = strictly ascending (signed); held until the next start
//   fail_idx     out  CNT_W   index i of the first word with word[i] <= word[i-1]; 0 if sorted
//   err_align    out  1       base_addr[1:0] != 0 at start; held until the next start
// BEHAVIOUR
//   Reset: state=IDLE; all outputs 0; mem_addr=0. Reset mid-scan aborts the scan; no done pulse.
//   State machine: IDLE -> REQ -> WAIT -> HOLD -> (REQ | DONE) -> IDLE.
//   IDLE: on start, latch base_addr and num_words, clear sorted, fail_idx, err_align and i.
//     base_addr misaligned: err_align=1, sorted=0, go to DONE (no reads).
//     N==0: sorted=1, go to DONE (no reads).
//     Otherwise: busy=1, go to REQ.
//   REQ (1 cycle): mem_rd=1, mem_addr = base + 4*i, modulo 2^ADDR_W (wraps silently).
//   WAIT (1 cycle): capture mem_rdata into out_data and into a prev register;
//     out_valid<=1. For i>0, if $signed(rdata) <= $signed(prev) and no failure has
//     been recorded yet, record fail_idx=i and flag a failure.
//   HOLD: out_valid and out_data stay stable until out_ready. On handshake,
//     out_valid<=0 and i<=i+1; if i==N-1 go to DONE, else go to REQ.
//     mem_rd stays 0 while in HOLD. The first handshake can happen in the first HOLD cycle.
//   The scan always streams all N words; a failure does not stop it.
//   DONE (1 cycle): done=1, busy<=0, and sorted = !failure (for non-error scans).
//     Return to IDLE. A start asserted in DONE is ignored.
//   start while busy is ignored.
//   Latency: start -> first mem_rd = 1 cycle. Minimum 3 cycles per word with
//     out_ready held high; the last handshake is followed by done the next cycle.
//   A single word (N==1) is read and streamed, and then sorted=1.
//   Comparison is signed 32-bit: 0x7FFFFFFF is the largest value and 0x80000000 the smallest.
// TESTING
//   Case 1. DM[512..556] = 55,88,0,22,77,11,99,33,110,66,121,44, base=512, N=12, out_ready=1
//     -> 12 words out in order, sorted=0, fail_idx=2, done pulses exactly once.
//   Case 2. The same addresses holding 0,11,22,...,121 -> sorted=1, fail_idx=0,
//     mem_addr sequence 512,516,...,556, and done 37 cycles after start.
//   Case 3. Words -1, 0, 0x7FFFFFFF, N=3 -> sorted=1.
//     Words 5, 5, N=2 -> sorted=0, fail_idx=1 (equal values fail).
//   Case 4. Hold out_ready=0 for 5 cycles on word 3 -> out_data and out_valid stable,
//     no mem_rd during the stall, and the scan completes correctly afterwards.
//   Case 5. N=0 -> done one cycle after the IDLE start, no mem_rd, sorted=1.
//     base=514 -> err_align=1, sorted=0, no mem_rd.
//   Case 6. Assert rst during WAIT of word 4 -> all outputs 0 next cycle, no done.
//     A new start then runs a full clean scan.

Source files
------------

// File: rtl/dm_scan_checker.sv
// dm_scan_checker: streams N memory words and checks they are strictly ascending (signed)
module dm_scan_checker #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  num_words,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              done,
    output logic              sorted,
    output logic [CNT_W-1:0]  fail_idx,
    output logic              err_align
);
    typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DONE} state_t;
    state_t state;
    logic [CNT_W-1:0] n_r, idx;
    logic [DATA_W-1:0] prev;
    logic failed, last;
    assign last = idx == n_r - CNT_W'(1);
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            n_r       <= '0;
            idx       <= '0;
            prev      <= '0;
            failed    <= 1'b0;
            mem_addr  <= '0;
            mem_rd    <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sorted    <= 1'b0;
            fail_idx  <= '0;
            err_align <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    n_r       <= num_words;
                    idx       <= '0;
                    failed    <= 1'b0;
                    fail_idx  <= '0;
                    mem_addr  <= base_addr;
                    err_align <= base_addr[1:0] != 2'b00;
                    if (base_addr[1:0] != 2'b00) begin
                        sorted <= 1'b0;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else if (num_words == '0) begin
                        sorted <= 1'b1;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        sorted <= 1'b0;
                        busy   <= 1'b1;
                        mem_rd <= 1'b1;
                        state  <= REQ;
                    end
                end
                REQ: begin
                    mem_rd <= 1'b0;
                    state  <= WAIT;
                end
                WAIT: begin
                    out_data  <= mem_rdata;
                    prev      <= mem_rdata;
                    out_valid <= 1'b1;
                    // only the first descending/equal pair is reported
                    if (idx != '0 && !failed && $signed(mem_rdata) <= $signed(prev)) begin
                        failed   <= 1'b1;
                        fail_idx <= idx;
                    end
                    state <= HOLD;
                end
                HOLD: if (out_ready) begin
                    out_valid <= 1'b0;
                    idx       <= idx + CNT_W'(1);
                    if (last) begin
                        sorted <= !failed;
                        done   <= 1'b1;
                        state  <= DONE;
                    end else begin
                        mem_rd   <= 1'b1;
                        mem_addr <= mem_addr + ADDR_W'(4);
                        state    <= REQ;
                    end
                end
                DONE: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dm_scan_checker.sv
// tb_dm_scan_checker: directed checks of dm_scan_checker against a small word-addressed memory
module tb_dm_scan_checker;
    logic        clk = 1'b0, rst = 1'b1, start = 1'b0, out_ready = 1'b1;
    logic [31:0] base_addr = '0, mem_rdata = '0, mem_addr, out_data;
    logic [15:0] num_words = '0, fail_idx;
    logic        mem_rd, out_valid, busy, done, sorted, err_align;
    logic [31:0] mem [0:1023];
    logic [31:0] outq[$], addrq[$];
    int          cyc = 0, done_cnt = 0;
    int          n_checks = 0, n_fail = 0;
    int          start_cyc, done_cyc, o0, a0, d0;
    localparam logic [31:0] C1 [12] = '{32'd55, 32'd88, 32'd0, 32'd22, 32'd77, 32'd11,
                                        32'd99, 32'd33, 32'd110, 32'd66, 32'd121, 32'd44};

    always #5 clk = ~clk;

    dm_scan_checker dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .num_words(num_words),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata), .out_data(out_data),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy), .done(done),
        .sorted(sorted), .fail_idx(fail_idx), .err_align(err_align)
    );

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (mem_rd) mem_rdata <= mem[mem_addr[11:2]];
    end

    always @(negedge clk) begin
        if (out_valid && out_ready) outq.push_back(out_data);
        if (mem_rd) addrq.push_back(mem_addr);
        if (done) done_cnt++;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_scan(input logic [31:0] b, input logic [15:0] n);
        @(posedge clk); #1;
        base_addr = b; num_words = n; start = 1'b1;
        start_cyc = cyc; o0 = outq.size(); a0 = addrq.size(); d0 = done_cnt;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!done && k < 400);
        if (!done) check("done_timeout", 0, 1);
        done_cyc = cyc;
    endtask

    task automatic wait_req(input logic [31:0] a);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!(mem_rd && mem_addr == a) && k < 400);
        if (k >= 400) check("req_timeout", 0, 1);
    endtask

    task automatic load_asc();
        for (int i = 0; i < 12; i++) mem[128+i] = 32'(11 * i);
    endtask

    task automatic check_asc_stream(input string tag);
        check(tag, 64'(outq.size() - o0), 12);
        for (int i = 0; i < 12 && o0 + i < outq.size(); i++) check(tag, outq[o0+i], 64'(11 * i));
    endtask

    initial begin
        logic [31:0] ref_d;
        logic        ok;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ctl", {busy, done, sorted, err_align, mem_rd, out_valid, fail_idx}, 0);
        check("rst_data", {mem_addr, out_data}, 0);
        rst = 1'b0;

        // unsorted array, first violation at index 2
        for (int i = 0; i < 12; i++) mem[128+i] = C1[i];
        start_scan(512, 12);
        wait_done();
        check("c1_sorted", sorted, 0);
        check("c1_fail_idx", fail_idx, 2);
        check("c1_busy", busy, 1);
        check("c1_cnt", 64'(outq.size() - o0), 12);
        for (int i = 0; i < 12 && o0 + i < outq.size(); i++) check("c1_word", outq[o0+i], C1[i]);
        repeat (5) @(negedge clk);
        check("c1_done_once", 64'(done_cnt - d0), 1);
        check("c1_busy_after", busy, 0);

        // ascending array: address sequence and latency
        load_asc();
        start_scan(512, 12);
        wait_done();
        check("c2_sorted", sorted, 1);
        check("c2_fail_idx", fail_idx, 0);
        check("c2_latency", 64'(done_cyc - start_cyc), 37);
        check("c2_rd_cnt", 64'(addrq.size() - a0), 12);
        for (int i = 0; i < 12 && a0 + i < addrq.size(); i++) check("c2_addr", addrq[a0+i], 64'(512 + 4 * i));
        check_asc_stream("c2_word");

        // signed boundaries
        mem[128] = 32'hFFFF_FFFF; mem[129] = 32'h0; mem[130] = 32'h7FFF_FFFF;
        start_scan(512, 3);
        wait_done();
        check("c3_signed_sorted", sorted, 1);
        check("c3_signed_fail", fail_idx, 0);
        mem[128] = 32'd5; mem[129] = 32'd5;
        start_scan(512, 2);
        wait_done();
        check("c3_equal_sorted", sorted, 0);
        check("c3_equal_fail", fail_idx, 1);
        mem[128] = 32'h7FFF_FFFF; mem[129] = 32'h8000_0000;
        start_scan(512, 2);
        wait_done();
        check("c3_wrap_sorted", sorted, 0);
        check("c3_wrap_fail", fail_idx, 1);
        mem[128] = 32'h8000_0000; mem[129] = 32'h7FFF_FFFF;
        start_scan(512, 2);
        wait_done();
        check("c3_minmax_sorted", sorted, 1);
        mem[128] = 32'd42;
        start_scan(512, 1);
        wait_done();
        check("c3_single_sorted", sorted, 1);
        check("c3_single_cnt", 64'(outq.size() - o0), 1);

        // back-pressure on word 3
        load_asc();
        start_scan(512, 12);
        wait_req(524);
        @(posedge clk); #1 out_ready = 1'b0;
        @(posedge clk); #1 ref_d = out_data;
        ok = 1'b1;
        repeat (5) begin
            @(negedge clk);
            ok = ok && out_valid && out_data == ref_d && !mem_rd;
        end
        check("c4_stall_word", ref_d, 33);
        check("c4_stall_stable", ok, 1);
        @(posedge clk); #1 out_ready = 1'b1;
        wait_done();
        check("c4_sorted", sorted, 1);
        check_asc_stream("c4_word");

        // empty scan and misaligned base
        start_scan(512, 0);
        wait_done();
        check("c5_n0_latency", 64'(done_cyc - start_cyc), 1);
        check("c5_n0_sorted", sorted, 1);
        check("c5_n0_rd", 64'(addrq.size() - a0), 0);
        start_scan(514, 4);
        wait_done();
        check("c5_align_err", err_align, 1);
        check("c5_align_sorted", sorted, 0);
        check("c5_align_rd", 64'(addrq.size() - a0), 0);
        start_scan(512, 2);
        wait_done();
        check("c5_align_clear", err_align, 0);

        // reset during WAIT of word 4, then a clean rerun
        start_scan(512, 12);
        wait_req(528);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        check("c6_rst_ctl", {busy, done, sorted, err_align, mem_rd, out_valid, fail_idx}, 0);
        check("c6_rst_data", {mem_addr, out_data}, 0);
        repeat (10) @(negedge clk);
        check("c6_no_done", 64'(done_cnt - d0), 0);
        start_scan(512, 12);
        wait_done();
        check("c6_sorted", sorted, 1);
        check("c6_latency", 64'(done_cyc - start_cyc), 37);
        check_asc_stream("c6_word");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
